// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style 4-bit bus receiver: state encoding,
// command prefixes, DDRAM line layout and the address-to-index mapping.
package lcd_pkg;

  typedef enum logic [2:0] {
    St8Bit,
    StHi,
    StLo,
    StExec,
    StClear
  } rx_state_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_DISP      = 8'h08;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_FUNC      = 8'h20;
  localparam logic [7:0] CMD_CGRAM     = 8'h40;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [6:0]  LINE1_BASE = 7'h00;
  localparam logic [6:0]  LINE2_BASE = 7'h40;
  localparam int unsigned LINE_CHARS = 16;
  localparam int unsigned NUM_CHARS  = 2 * LINE_CHARS;
  localparam logic [7:0]  BLANK_CHAR = 8'h20;

  // Returns {hit, index}; hit is 0 for addresses outside both visible lines.
  function automatic logic [5:0] ddram_index(input logic [6:0] addr);
    logic [6:0] off1;
    logic [6:0] off2;
    logic [5:0] idx;
    off1 = addr - LINE1_BASE;
    off2 = addr - LINE2_BASE;
    idx  = '0;
    if (off1 < 7'(LINE_CHARS)) begin
      idx = {1'b1, 5'(off1)};
    end else if (off2 < 7'(LINE_CHARS)) begin
      idx = {1'b1, 5'(off2) + 5'(LINE_CHARS)};
    end
    return idx;
  endfunction

endpackage

// File: rtl/lcd_pin_sync.sv
// Bus-pin synchronizer: SYNC_STAGES flops on E/RW/RS/DB, E edge pulses, and a
// capture of nibble and RS from the last cycle the synchronized E was high.
module lcd_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] db_i,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  output logic       e_o,
  output logic       rw_o,
  output logic       e_rise_o,
  output logic       e_fall_o,
  output logic [3:0] nib_o,
  output logic       rs_o
);

  // Bundle layout: {e, rw, rs, db[3:0]}
  logic [6:0] sync_q [SYNC_STAGES];
  logic       e_prev_q;
  logic [3:0] nib_q;
  logic       rs_q;
  logic [6:0] sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      e_prev_q <= 1'b0;
      nib_q    <= '0;
      rs_q     <= 1'b0;
    end else begin
      sync_q[0] <= {e_i, rw_i, rs_i, db_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      e_prev_q <= sync_last[6];
      if (sync_last[6]) begin
        nib_q <= sync_last[3:0];
        rs_q  <= sync_last[4];
      end
    end
  end

  assign e_o      = sync_last[6];
  assign rw_o     = sync_last[5];
  assign e_rise_o = sync_last[6] & ~e_prev_q;
  assign e_fall_o = ~sync_last[6] & e_prev_q;
  assign nib_o    = nib_q;
  assign rs_o     = rs_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Display-side receiver for the 4-bit LCD bus: init handshake tracking, nibble
// assembly, command decode, 32-char shadow DDRAM and bus timing checks.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned E_MIN_HIGH  = 12,
  parameter int unsigned BYTE_GAP    = 1500,
  parameter int unsigned CLEAR_GAP   = 80000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   LCD_DB,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  output logic [255:0] char_output,
  output logic [6:0]   addr_out,
  output logic         mode_4bit,
  output logic         disp_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         byte_valid,
  output logic         byte_rs,
  output logic [7:0]   byte_data,
  output logic         timing_err,
  output logic         read_err
);

  localparam int unsigned GapMaxInt = (CLEAR_GAP > BYTE_GAP) ? CLEAR_GAP : BYTE_GAP;
  localparam int unsigned EW = $clog2(E_MIN_HIGH + 2);
  localparam int unsigned GW = $clog2(GapMaxInt + 2);
  localparam logic [EW-1:0] EMin   = EW'(E_MIN_HIGH);
  localparam logic [GW-1:0] GByte  = GW'(BYTE_GAP);
  localparam logic [GW-1:0] GClear = GW'(CLEAR_GAP);
  localparam logic [GW-1:0] GMax   = GW'(GapMaxInt);

  logic       e_sync, rw_sync, e_rise, e_fall, rs_cap;
  logic [3:0] nib;

  lcd_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .db_i    (LCD_DB),
    .e_i     (LCD_E),
    .rs_i    (LCD_RS),
    .rw_i    (LCD_RW),
    .e_o     (e_sync),
    .rw_o    (rw_sync),
    .e_rise_o(e_rise),
    .e_fall_o(e_fall),
    .nib_o   (nib),
    .rs_o    (rs_cap)
  );

  rx_state_e      state_q, state_d;
  logic [3:0]     hi_q, hi_d;
  logic           hi_rs_q, hi_rs_d;
  logic [7:0]     byte_q, byte_d;
  logic           byte_rs_q, byte_rs_d;
  logic [6:0]     addr_q, addr_d;
  logic           inc_q, inc_d;
  logic           mode4_q, mode4_d;
  logic           disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic [255:0]   char_q, char_d;
  logic [4:0]     clr_idx_q, clr_idx_d;
  logic [EW-1:0]  ehigh_q, ehigh_d;
  logic           rd_cyc_q, rd_cyc_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           gap_armed_q, gap_armed_d;
  logic           clr_gap_q, clr_gap_d;
  logic           terr_q, terr_d, rerr_q, rerr_d;
  logic           accept;
  logic [5:0]     wr_idx;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    hi_rs_d     = hi_rs_q;
    byte_d      = byte_q;
    byte_rs_d   = byte_rs_q;
    addr_d      = addr_q;
    inc_d       = inc_q;
    mode4_d     = mode4_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    char_d      = char_q;
    clr_idx_d   = clr_idx_q;
    ehigh_d     = ehigh_q;
    rd_cyc_d    = rd_cyc_q;
    gap_d       = gap_q;
    gap_armed_d = gap_armed_q;
    clr_gap_d   = clr_gap_q;
    terr_d      = 1'b0;
    rerr_d      = 1'b0;
    wr_idx      = '0;

    if (gap_q != GMax) begin
      gap_d = gap_q + 1'b1;
    end

    if (e_rise) begin
      ehigh_d  = EW'(1);
      rd_cyc_d = rw_sync;
      rerr_d   = rw_sync;
      if (gap_armed_q) begin
        gap_armed_d = 1'b0;
        if (gap_q < (clr_gap_q ? GClear : GByte)) begin
          terr_d = 1'b1;
        end
      end
    end else if (e_sync && ehigh_q != EMin) begin
      ehigh_d = ehigh_q + 1'b1;
    end

    // Falls that end a read cycle are not bus writes and are dropped entirely.
    accept = e_fall & ~rd_cyc_q;
    if (e_fall) begin
      rd_cyc_d = 1'b0;
    end
    if (accept && ehigh_q < EMin) begin
      terr_d = 1'b1;
    end

    unique case (state_q)
      St8Bit: begin
        if (accept) begin
          gap_d       = '0;
          gap_armed_d = 1'b1;
          clr_gap_d   = 1'b0;
          if (!rs_cap && nib == 4'h2) begin
            mode4_d = 1'b1;
            state_d = StHi;
          end
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = nib;
          hi_rs_d = rs_cap;
          state_d = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          byte_d      = {hi_q, nib};
          byte_rs_d   = hi_rs_q;
          gap_d       = '0;
          gap_armed_d = 1'b1;
          clr_gap_d   = 1'b0;
          state_d     = StExec;
        end
      end
      StExec: begin
        state_d = StHi;
        if (byte_rs_q) begin
          wr_idx = ddram_index(addr_q);
          if (wr_idx[5]) begin
            char_d[{wr_idx[4:0], 3'b000} +: 8] = byte_q;
          end
          addr_d = inc_q ? addr_q + 7'd1 : addr_q - 7'd1;
        end else if (|(byte_q & CMD_SET_DDRAM)) begin
          addr_d = byte_q[6:0];
        end else if (|(byte_q & (CMD_CGRAM | CMD_FUNC | CMD_SHIFT))) begin
          // CGRAM, cursor shift and function set change nothing mirrored here;
          // DL=1 never drops the interface back to 8-bit mode.
          state_d = StHi;
        end else if (|(byte_q & CMD_DISP)) begin
          {disp_d, cur_d, blink_d} = byte_q[2:0];
        end else if (|(byte_q & CMD_ENTRY)) begin
          inc_d = byte_q[1];
        end else if (|(byte_q & CMD_HOME)) begin
          addr_d = '0;
        end else if (byte_q == CMD_CLEAR) begin
          clr_idx_d = '0;
          clr_gap_d = 1'b1;
          state_d   = StClear;
        end
      end
      StClear: begin
        char_d[{clr_idx_q, 3'b000} +: 8] = BLANK_CHAR;
        clr_idx_d = clr_idx_q + 5'd1;
        if (e_fall) begin
          terr_d = 1'b1;
        end
        if (clr_idx_q == 5'(NUM_CHARS - 1)) begin
          addr_d  = '0;
          inc_d   = 1'b1;
          state_d = StHi;
        end
      end
      default: state_d = St8Bit;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= St8Bit;
      hi_q        <= '0;
      hi_rs_q     <= 1'b0;
      byte_q      <= '0;
      byte_rs_q   <= 1'b0;
      addr_q      <= '0;
      inc_q       <= 1'b1;
      mode4_q     <= 1'b0;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      char_q      <= {NUM_CHARS{BLANK_CHAR}};
      clr_idx_q   <= '0;
      ehigh_q     <= '0;
      rd_cyc_q    <= 1'b0;
      gap_q       <= '0;
      gap_armed_q <= 1'b0;
      clr_gap_q   <= 1'b0;
      terr_q      <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      hi_rs_q     <= hi_rs_d;
      byte_q      <= byte_d;
      byte_rs_q   <= byte_rs_d;
      addr_q      <= addr_d;
      inc_q       <= inc_d;
      mode4_q     <= mode4_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      char_q      <= char_d;
      clr_idx_q   <= clr_idx_d;
      ehigh_q     <= ehigh_d;
      rd_cyc_q    <= rd_cyc_d;
      gap_q       <= gap_d;
      gap_armed_q <= gap_armed_d;
      clr_gap_q   <= clr_gap_d;
      terr_q      <= terr_d;
      rerr_q      <= rerr_d;
    end
  end

  assign char_output = char_q;
  assign addr_out    = addr_q;
  assign mode_4bit   = mode4_q;
  assign disp_on     = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign byte_valid  = (state_q == StExec);
  assign byte_rs     = byte_rs_q;
  assign byte_data   = byte_q;
  assign timing_err  = terr_q;
  assign read_err    = rerr_q;

endmodule
